rf_wp_arbiter: RTL and testbench
================================

# rf_wp_arbiter

Round-robin arbiter for the single register-file write port in the MIPS datapath. Up to eight write requesters (ALU result, load data, link address, etc.) each present a 5-bit destination register. The arbiter grants one requester per cycle and drives the 3-bit `choose` select of the downstream 8:1 5-bit mux5 address mux and the matching data mux. It also produces the GRF write enable, and supports locked bursts so one requester can hold the port for a bounded number of consecutive writes.

## Interface
- `N_REQ`, 8, number of requesters; legal range 2..8; unused select codes are never issued.
- `MAX_BURST`, 4, maximum consecutive grants to one locked requester; legal range 1..15.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  request per requester; held high until granted.
- `lock`  in  N_REQ  burst request; meaningful only while the same bit of `req` is high.
- `addr_flat`  in  5*N_REQ  destination register of requester i at bits [5i+4:5i].
- `grant`  out  N_REQ  one-hot grant, registered.
- `choose`  out  3  index of the granted requester, registered; feeds the mux5 `choose` input.
- `wr_en`  out  1  GRF write enable for the granted write, registered.
- `busy`  out  1  high when `grant` is non-zero.

## Operation
- State machine `st`:
  - IDLE: no grant.
  - GRANT: first grant to a requester, `cnt`=0.
  - BURST: repeated grant to the same locked requester, `cnt`>0.
- Round-robin pointer `ptr` (3 bits) identifies the highest-priority requester. The search runs `ptr`, `ptr`+1, …, wrapping modulo N_REQ.
- Each edge with `reset` low:
  - Burst continue: if the current holder i has `req[i]`=1, `lock[i]`=1 and `cnt` < MAX_BURST-1, then i is re-granted, `cnt`++, and the next state is BURST.
  - Normal arbitration, any other case:
    - The current holder i is masked out of the search.
    - Winner w gets `grant`=1<<w, `choose`=w, `ptr`=(w+1) mod N_REQ, `cnt`=0, next state GRANT.
  - Masked holder is the only requester: if the masked search finds nothing but `req[i]` is still high, i is granted again as a new GRANT with `cnt`=0. The port never idles while any request is pending.
  - No request at all: next state IDLE, `grant`=0, `wr_en`=0. `choose` holds its last value.
- `wr_en` = 1 in the same cycle as any non-zero `grant`. Zero filtering is described under Configuration.
- Requester handshake: a requester drops `req` in the cycle after it sees its grant, or keeps it high with `lock` to continue a burst. Keeping `req` high without `lock` counts as a new request at lowest priority.
- Bits of `req` at index ≥ N_REQ are ignored. `choose` never exceeds N_REQ-1.

## Timing
- Latency: `req` sampled at edge t, so `grant`, `choose` and `wr_en` are valid from t+1.
- Full-rate operation: one grant per cycle, back-to-back, with no bubble on handover.
- Reset, including mid-burst: next edge forces `grant`=0, `choose`=0, `wr_en`=0, `busy`=0, `ptr`=0, `cnt`=0, state IDLE. Pending requests are re-arbitrated from index 0 on the first edge after `reset` falls.
- Simultaneous events: all simultaneous requests resolve by `ptr` order. Dropping `lock` mid-burst ends the burst at the next edge.
- Burst cap: after MAX_BURST consecutive grants, the holder is masked for one arbitration. With MAX_BURST=1, `lock` has no effect.
- Wrap: `ptr` from N_REQ-1 wraps to 0.

## Configuration
- `RF_ARB_ZERO_FILTER_EN`:
  - Defined: `wr_en` is forced to 0 when the granted requester's address equals 5'd0. Grant, pointer and burst counting are unchanged, so the request is still consumed.
  - Undefined: `wr_en` follows `grant` regardless of address, and the GRF is responsible for ignoring $0.

## Structure
- Shared package/header `rf_arb_defs`:
  - state encodings IDLE=2'd0, GRANT=2'd1, BURST=2'd2
  - `CHOOSE_W`=3
  - `ADDR_W`=5
  - `CNT_W`=4
- Sub-module `rr_pick`: combinational rotate-priority encoder. Inputs are the masked request vector and `ptr`; outputs are `found` and the winner index. Instantiated once.

## Test plan
- Reset then `req`=8'b0000_0001 → `grant`=8'h01, `choose`=0, `wr_en`=1 one cycle later; drop `req` → IDLE, `busy`=0.
- `req`=8'hFF held, `lock`=0 → `choose` cycles 0,1,2,…,7,0 with one grant per cycle and no gaps.
- `req[3]`=1, `lock[3]`=1 held, `req[5]`=1, MAX_BURST=4 → `choose`=3 for 4 cycles, then 5, then 3 again.
- Burst in progress at `cnt`=2, assert `reset` for one cycle → all outputs 0, `ptr`=0; release with `req`=8'h30 → `choose`=4 first.
- With `RF_ARB_ZERO_FILTER_EN`, requester 2 with address 0 granted → `grant`=8'h04 and `wr_en`=0; without the macro → `wr_en`=1.

Source files
------------

// File: rtl/rf_arb_defs.sv
// rtl/rf_arb_defs.sv - shared encodings and widths for the register-file write-port arbiter
package rf_arb_defs;

  localparam int CHOOSE_W = 3;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

endpackage

// File: rtl/rf_wp_arbiter_rr_pick.sv
// rtl/rf_wp_arbiter_rr_pick.sv - rotate-priority encoder: first set request at or after ptr
module rr_pick
  import rf_arb_defs::*;
#(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0]    req_m,
  input  logic [CHOOSE_W-1:0] ptr,
  output logic                found,
  output logic [CHOOSE_W-1:0] win
);

  logic [CHOOSE_W:0] idx;

  // Walk ptr, ptr+1, ... modulo N_REQ and keep the first requester seen.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (CHOOSE_W+1)'(k);
      if (idx >= (CHOOSE_W+1)'(N_REQ)) begin
        idx = idx - (CHOOSE_W+1)'(N_REQ);
      end
      if (!found && req_m[idx[CHOOSE_W-1:0]]) begin
        found = 1'b1;
        win   = idx[CHOOSE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wp_arbiter.sv
// rtl/rf_wp_arbiter.sv - round-robin GRF write-port arbiter with locked bursts (option: RF_ARB_ZERO_FILTER_EN)
module rf_wp_arbiter
  import rf_arb_defs::*;
#(
  parameter int N_REQ     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [ADDR_W*N_REQ-1:0] addr_flat,
  output logic [N_REQ-1:0]        grant,
  output logic [CHOOSE_W-1:0]     choose,
  output logic                    wr_en,
  output logic                    busy
);

  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [1:0]          st;
  logic [CHOOSE_W-1:0] ptr;
  logic [CNT_W-1:0]    cnt;

  logic                hold_v;
  logic [N_REQ-1:0]    req_m;
  logic                burst_go;
  logic                found;
  logic [CHOOSE_W-1:0] win;

  logic [1:0]          nxt_st;
  logic [CHOOSE_W-1:0] nxt_idx;
  logic [CHOOSE_W-1:0] nxt_ptr;
  logic [CNT_W-1:0]    nxt_cnt;
  logic                nxt_gv;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                nxt_wr;

  function automatic logic [CHOOSE_W-1:0] ptr_after(input logic [CHOOSE_W-1:0] i);
    return (i == CHOOSE_W'(N_REQ - 1)) ? '0 : i + CHOOSE_W'(1);
  endfunction

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_m (req_m),
    .ptr   (ptr),
    .found (found),
    .win   (win)
  );

  // Decide next holder: continue a locked burst, else rotate with the holder masked out.
  always_comb begin
    hold_v   = (st != ST_IDLE);
    req_m    = req & ~(hold_v ? (ONE << choose) : '0);
    burst_go = hold_v && req[choose] && lock[choose] && (cnt < CNT_LAST);
    nxt_st   = ST_IDLE;
    nxt_idx  = choose;
    nxt_ptr  = ptr;
    nxt_cnt  = '0;
    nxt_gv   = 1'b0;
    if (burst_go) begin
      nxt_st  = ST_BURST;
      nxt_cnt = cnt + CNT_W'(1);
      nxt_gv  = 1'b1;
    end else if (found) begin
      nxt_st  = ST_GRANT;
      nxt_idx = win;
      nxt_ptr = ptr_after(win);
      nxt_gv  = 1'b1;
    end else if (hold_v && req[choose]) begin
      // Holder is the only one asking: serve it again rather than idle the port.
      nxt_st  = ST_GRANT;
      nxt_ptr = ptr_after(choose);
      nxt_gv  = 1'b1;
    end
  end

  // Write enable for the upcoming grant, optionally suppressing writes to $0.
  always_comb begin
    nxt_addr = addr_flat[int'(nxt_idx)*ADDR_W +: ADDR_W];
`ifdef RF_ARB_ZERO_FILTER_EN
    nxt_wr   = nxt_gv && (nxt_addr != '0);
`else
    nxt_wr   = nxt_gv;
`endif
  end

  // Register state and all outputs; choose keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= ST_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      choose <= '0;
      grant  <= '0;
      wr_en  <= 1'b0;
    end else begin
      st     <= nxt_st;
      ptr    <= nxt_ptr;
      cnt    <= nxt_cnt;
      choose <= nxt_idx;
      grant  <= nxt_gv ? (ONE << nxt_idx) : '0;
      wr_en  <= nxt_wr;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_rf_wp_arbiter.sv
// tb/tb_rf_wp_arbiter.sv - self-checking bench for rf_wp_arbiter (model honours RF_ARB_ZERO_FILTER_EN)
module tb_rf_wp_arbiter;

  localparam int N  = 8;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = '0;
  logic [7:0]  lock = '0;
  logic [39:0] addr_flat;
  logic [7:0]  grant;
  logic [2:0]  choose;
  logic        wr_en;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // model state
  int         m_hold = -1;
  int         m_run  = 0;
  int         m_ptr  = 0;
  int         m_choose = 0;
  logic [7:0] m_grant = '0;
  bit         m_wr = 1'b0;

  rf_wp_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .addr_flat (addr_flat),
    .grant     (grant),
    .choose    (choose),
    .wr_en     (wr_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic bit addr_ok(input int i);
    logic [4:0] a;
    a = addr_flat[i*5 +: 5];
`ifdef RF_ARB_ZERO_FILTER_EN
    return a != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  // reference model: holder identity plus count of consecutive grants
  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_hold = -1; m_run = 0; m_ptr = 0; m_choose = 0;
    end else if (m_hold >= 0 && req[m_hold] && lock[m_hold] && m_run < MB) begin
      m_run = m_run + 1;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req[c] && c != m_hold) w = c;
      end
      if (w < 0 && m_hold >= 0 && req[m_hold]) w = m_hold;
      if (w >= 0) begin
        m_hold = w; m_run = 1; m_ptr = (w + 1) % N; m_choose = w;
      end else begin
        m_hold = -1; m_run = 0;
      end
    end
    m_grant = (m_hold >= 0) ? (8'h01 << m_hold) : 8'h00;
    m_wr    = (m_hold >= 0) && addr_ok(m_hold);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_grant",  int'(grant),  int'(m_grant));
      chk("mdl_choose", int'(choose), m_choose);
      chk("mdl_wr_en",  int'(wr_en),  int'(m_wr));
      chk("mdl_busy",   int'(busy),   int'(m_grant != 0));
    end
  end

  task automatic cyc(input bit r, input logic [7:0] rq, input logic [7:0] lk);
    @(negedge clk);
    reset = r; req = rq; lock = lk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq3 [6];
    seq3 = '{3, 3, 3, 3, 5, 3};
    for (int i = 0; i < N; i++) addr_flat[i*5 +: 5] = 5'(i + 8);
    addr_flat[2*5 +: 5] = 5'd0;

    // reset state
    cyc(1'b1, 8'h00, 8'h00);
    chk_en = 1'b1;
    chk("rst_grant",  int'(grant),  0);
    chk("rst_choose", int'(choose), 0);
    chk("rst_wr_en",  int'(wr_en),  0);
    chk("rst_busy",   int'(busy),   0);

    // single request, then drop
    cyc(1'b0, 8'h01, 8'h00);
    chk("one_grant",  int'(grant),  8'h01);
    chk("one_choose", int'(choose), 0);
    chk("one_wr_en",  int'(wr_en),  1);
    cyc(1'b0, 8'h00, 8'h00);
    chk("drop_busy",  int'(busy),   0);
    chk("drop_wr_en", int'(wr_en),  0);

    // all request, no lock: full-rate rotation with wrap
    cyc(1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, 8'hFF, 8'h00);
      chk("rot_choose", int'(choose), k % 8);
      chk("rot_grant",  int'(grant),  1 << (k % 8));
    end

    // locked burst capped at MAX_BURST, then handover and back
    cyc(1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 8'h28, 8'h08);
      chk("burst_choose", int'(choose), seq3[k]);
    end

    // reset mid-burst, then restart from index 0
    cyc(1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h28, 8'h08);
    chk("mid_choose", int'(choose), 3);
    cyc(1'b1, 8'h28, 8'h08);
    chk("mrst_grant",  int'(grant),  0);
    chk("mrst_choose", int'(choose), 0);
    chk("mrst_wr_en",  int'(wr_en),  0);
    chk("mrst_busy",   int'(busy),   0);
    cyc(1'b0, 8'h30, 8'h00);
    chk("post_choose0", int'(choose), 4);
    cyc(1'b0, 8'h30, 8'h00);
    chk("post_choose1", int'(choose), 5);

    // zero-address requester
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h04, 8'h00);
    chk("zero_grant", int'(grant), 8'h04);
`ifdef RF_ARB_ZERO_FILTER_EN
    chk("zero_wr_en", int'(wr_en), 0);
`else
    chk("zero_wr_en", int'(wr_en), 1);
`endif
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
